// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//
// Memory-mapped interval timer and interrupt controller for the single-cycle
// MIPS CPU. Firmware programs a reload value (TH), a running count (TL) and a
// control word (TCON). The count advances once per prescaler tick. When it
// passes 32'hFFFF_FFFF it reloads from TH and, if enabled, raises the
// interrupt flag. The ISR acknowledges the interrupt by clearing TCON bits.
//
// Register map (byte offset from BASE_ADDR):
//   0x00 TH    reload value, R/W
//   0x04 TL    count value,  R/W
//   0x08 TCON  [0] TEN  [1] TIE  [2] TIF  [3] ONESHOT, [31:4] read 0
//   0x0C       reads 0, writes ignored
//
// Ports:
//   clk        system clock, rising-edge
//   reset      asynchronous, active-low reset
//   addr       bus byte address (word aligned)
//   wdata      bus write data
//   memread    bus read strobe
//   memwrite   bus write strobe, commits on the rising edge
//   rdata      combinational read data (pre-write value on read+write)
//   irq        registered interrupt request, TIE & TIF
//   state_dbg  current FSM state (0 = IDLE, 1 = COUNT)
// -----------------------------------------------------------------------------
module timer_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESC_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);

    state_t      state, state_next;
    logic [15:0] presc_cnt, presc_next;
    logic [31:0] th, th_next;
    logic [31:0] tl, tl_next;
    logic        ten, ten_next;
    logic        tie, tie_next;
    logic        tif, tif_next;
    logic        oneshot, oneshot_next;
    logic        irq_q;

    logic        hit;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick;
    logic        overflow;
    logic        set_tif;

    // Address decode: upper 28 bits select the 16-byte window.
    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_th   = memwrite && hit && (addr[3:2] == 2'd0);
    assign wr_tl   = memwrite && hit && (addr[3:2] == 2'd1);
    assign wr_tcon = memwrite && hit && (addr[3:2] == 2'd2);

    assign tick     = (state == COUNT) && (presc_cnt == PRESC_LAST);
    assign overflow = tick && (tl == 32'hFFFF_FFFF);
    // Uses the TIE held before any same-edge TCON write.
    assign set_tif  = overflow && tie;

    // Read path is purely combinational, so a read concurrent with a write
    // returns the old register value.
    always_comb begin
        rdata = 32'h0;
        if (memread && hit) begin
            case (addr[3:2])
                2'd0:    rdata = th;
                2'd1:    rdata = tl;
                2'd2:    rdata = {28'h0, oneshot, tif, tie, ten};
                default: rdata = 32'h0;
            endcase
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        th_next      = th;
        tl_next      = tl;
        ten_next     = ten;
        tie_next     = tie;
        tif_next     = tif | set_tif;
        oneshot_next = oneshot;
        state_next   = state;
        presc_next   = 16'd0;

        if (wr_th) begin
            th_next = wdata;
        end

        // A bus write to TL takes priority over increment and reload; the
        // reload uses the TH value from before any same-edge TH write.
        if (wr_tl) begin
            tl_next = wdata;
        end else if (overflow) begin
            tl_next = th;
        end else if (tick) begin
            tl_next = tl + 32'd1;
        end

        if (overflow && oneshot) begin
            ten_next = 1'b0;
        end

        // A TCON write overrides the one-shot auto-clear, but the overflow
        // flag is OR'ed in so a coincident overflow is never lost.
        if (wr_tcon) begin
            ten_next     = wdata[0];
            tie_next     = wdata[1];
            tif_next     = wdata[2] | set_tif;
            oneshot_next = wdata[3];
        end

        // The FSM follows TEN on the same edge that TEN changes.
        case (state)
            IDLE:    state_next = ten_next ? COUNT : IDLE;
            COUNT:   state_next = ten_next ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase

        // Prescaler only runs while staying in COUNT; entering COUNT from
        // IDLE always begins a fresh period at 0.
        if (state == COUNT && state_next == COUNT) begin
            presc_next = tick ? 16'd0 : presc_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc_cnt <= 16'd0;
            th        <= 32'h0;
            tl        <= 32'h0;
            ten       <= 1'b0;
            tie       <= 1'b0;
            tif       <= 1'b0;
            oneshot   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state     <= state_next;
            presc_cnt <= presc_next;
            th        <= th_next;
            tl        <= tl_next;
            ten       <= ten_next;
            tie       <= tie_next;
            tif       <= tif_next;
            oneshot   <= oneshot_next;
            // Registered from the current flags: lags the flag change by one edge.
            irq_q     <= tie & tif;
        end
    end

    assign irq       = irq_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_ctrl
//
// Directed bench for timer_irq_ctrl. Two instances share the address/data
// bus: dut1 with PRESC_DIV=1 and dut4 with PRESC_DIV=4, each with its own
// read/write strobes. Bus handshake: inputs change on the falling edge, a
// write commits on the following rising edge, and reads sample rdata
// combinationally 1 ns after the strobe is raised.
// -----------------------------------------------------------------------------
module tb_timer_irq_ctrl;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_RSV  = 32'h4000_000C;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mr1, mw1, mr4, mw4;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;
  logic        st1, st4;

  int checks = 0;
  int errors = 0;

  timer_irq_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESC_DIV(1)) dut1 (
    .clk(clk), .reset(reset_n), .addr(addr), .wdata(wdata),
    .memread(mr1), .memwrite(mw1), .rdata(rd1), .irq(irq1), .state_dbg(st1)
  );

  timer_irq_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESC_DIV(4)) dut4 (
    .clk(clk), .reset(reset_n), .addr(addr), .wdata(wdata),
    .memread(mr4), .memwrite(mw4), .rdata(rd4), .irq(irq4), .state_dbg(st4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic bus_write(input bit which, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    if (which) mw4 = 1'b1;
    else       mw1 = 1'b1;
    @(posedge clk);
    #1;
    mw1 = 1'b0;
    mw4 = 1'b0;
  endtask

  task automatic bus_read(input bit which, input logic [31:0] a, output logic [31:0] d);
    addr = a;
    if (which) mr4 = 1'b1;
    else       mr1 = 1'b1;
    #1;
    d   = which ? rd4 : rd1;
    mr1 = 1'b0;
    mr4 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    bus_read(0, A_TH, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_th: got %h exp %h", v, 32'h0); end
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_tl: got %h exp %h", v, 32'h0); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_tcon: got %h exp %h", v, 32'h0); end
    bus_read(0, A_RSV, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_rsv: got %h exp %h", v, 32'h0); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq1); end
    bus_read(1, A_TCON, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_tcon4: got %h exp %h", v, 32'h0); end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    bus_write(0, A_TH, 32'hFFFF_8000);
    bus_write(0, A_RSV, 32'hDEAD_BEEF);
    bus_write(0, 32'h5000_0000, 32'h1111_2222);
    bus_write(0, 32'h4000_0010, 32'h3333_4444);
    bus_read(0, A_TH, v);
    checks++; if (v !== 32'hFFFF_8000) begin errors++; $display("FAIL decode_th: got %h exp %h", v, 32'hFFFF_8000); end
    bus_read(0, A_RSV, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL decode_rsv: got %h exp %h", v, 32'h0); end
    bus_read(0, 32'h4000_0010, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL decode_outside: got %h exp %h", v, 32'h0); end
    // No read strobe: bus returns zero even with a valid address.
    addr = A_TH;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL decode_no_rd: got %h exp %h", rd1, 32'h0); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    bus_write(0, A_TL, 32'hFFFF_FFFF);
    bus_write(0, A_TCON, 32'h3);
    @(posedge clk); #1;              // first tick: overflow edge
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hFFFF_8000) begin errors++; $display("FAIL ovf_reload: got %h exp %h", v, 32'hFFFF_8000); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h7) begin errors++; $display("FAIL ovf_tif: got %h exp %h", v, 32'h7); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL ovf_irq_early: got %b exp 0", irq1); end
    @(posedge clk); #1;
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL ovf_irq_rise: got %b exp 1", irq1); end
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hFFFF_8001) begin errors++; $display("FAIL ovf_incr: got %h exp %h", v, 32'hFFFF_8001); end
    repeat (32766) @(posedge clk);
    #1;
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_period_end: got %h exp %h", v, 32'hFFFF_FFFF); end
    @(posedge clk); #1;
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hFFFF_8000) begin errors++; $display("FAIL ovf_second: got %h exp %h", v, 32'hFFFF_8000); end
  endtask

  task automatic test_isr_ack();
    logic [31:0] v;
    bus_write(0, A_TCON, 32'h7 & 32'hFFFF_FFF9);
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ack_tcon: got %h exp %h", v, 32'h1); end
    @(posedge clk); #1;
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL ack_irq_fall: got %b exp 0", irq1); end
    bus_write(0, A_TCON, 32'h3);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL ack_irq_stays: got %b exp 0", irq1); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL ack_tcon_run: got %h exp %h", v, 32'h3); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    // TCON write on the overflow edge keeps the flag.
    bus_write(0, A_TCON, 32'h0);
    bus_write(0, A_TL, 32'hFFFF_FFFF);
    bus_write(0, A_TH, 32'h1234);
    bus_write(0, A_TCON, 32'h3);
    bus_write(0, A_TCON, 32'h3);
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h7) begin errors++; $display("FAIL sim_tcon_tif: got %h exp %h", v, 32'h7); end
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'h1234) begin errors++; $display("FAIL sim_tcon_tl: got %h exp %h", v, 32'h1234); end
    @(posedge clk); #1;
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL sim_tcon_irq: got %b exp 1", irq1); end
    // TL write on the overflow edge wins over the reload.
    bus_write(0, A_TCON, 32'h0);
    bus_write(0, A_TL, 32'hFFFF_FFFF);
    bus_write(0, A_TCON, 32'h3);
    bus_write(0, A_TL, 32'h10);
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL sim_tl_val: got %h exp %h", v, 32'h10); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h7) begin errors++; $display("FAIL sim_tl_tif: got %h exp %h", v, 32'h7); end
    // TH write on the reload edge: TL takes the old TH.
    bus_write(0, A_TCON, 32'h0);
    bus_write(0, A_TL, 32'hFFFF_FFFF);
    bus_write(0, A_TH, 32'hAA);
    bus_write(0, A_TCON, 32'h1);
    bus_write(0, A_TH, 32'hBB);
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hAA) begin errors++; $display("FAIL sim_th_tl: got %h exp %h", v, 32'hAA); end
    bus_read(0, A_TH, v);
    checks++; if (v !== 32'hBB) begin errors++; $display("FAIL sim_th_th: got %h exp %h", v, 32'hBB); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL sim_th_tcon: got %h exp %h", v, 32'h1); end
    // TCON write setting TEN on a one-shot overflow edge keeps TEN.
    bus_write(0, A_TCON, 32'h0);
    bus_write(0, A_TL, 32'hFFFF_FFFF);
    bus_write(0, A_TCON, 32'h9);
    bus_write(0, A_TCON, 32'h9);
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h9) begin errors++; $display("FAIL sim_os_ten: got %h exp %h", v, 32'h9); end
    @(posedge clk); #1;
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'hBC) begin errors++; $display("FAIL sim_os_run: got %h exp %h", v, 32'hBC); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    bus_write(0, A_TCON, 32'h0);
    bus_write(0, A_TH, 32'h5);
    bus_write(0, A_TL, 32'hFFFF_FFFE);
    bus_write(0, A_TCON, 32'h9);
    repeat (2) @(posedge clk);
    #1;
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL os_tl: got %h exp %h", v, 32'h5); end
    bus_read(0, A_TCON, v);
    checks++; if (v !== 32'h8) begin errors++; $display("FAIL os_tcon: got %h exp %h", v, 32'h8); end
    repeat (5) @(posedge clk);
    #1;
    bus_read(0, A_TL, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL os_tl_hold: got %h exp %h", v, 32'h5); end
    checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL os_irq: got %b exp 0", irq1); end
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    bus_write(1, A_TH, 32'h55);
    bus_write(1, A_TCON, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL presc_early: got %h exp %h", v, 32'h0); end
    @(posedge clk); #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL presc_first: got %h exp %h", v, 32'h1); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL presc_second: got %h exp %h", v, 32'h2); end
    // Clear TEN one cycle into the next period.
    bus_write(1, A_TCON, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL presc_frozen: got %h exp %h", v, 32'h2); end
    bus_write(1, A_TCON, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL presc_restart_early: got %h exp %h", v, 32'h2); end
    @(posedge clk); #1;
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL presc_restart: got %h exp %h", v, 32'h3); end
    // Asynchronous reset in the middle of a cycle.
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    bus_read(1, A_TH, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_th: got %h exp %h", v, 32'h0); end
    bus_read(1, A_TL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_tl: got %h exp %h", v, 32'h0); end
    bus_read(1, A_TCON, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL areset_tcon: got %h exp %h", v, 32'h0); end
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b exp 0", irq4); end
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    mr1 = 1'b0; mw1 = 1'b0; mr4 = 1'b0; mw4 = 1'b0;
    #22;
    reset_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_decode();
    test_overflow();
    test_isr_ack();
    test_simultaneous();
    test_oneshot();
    test_prescaler();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
